// File: rtl/mig_app_responder.sv
// MIG 7-series app-interface responder: on-chip RAM behind calibration delay, refresh stalls
// and a write-data FIFO. Define MIG_RESP_MASK_EN to honour app_wdf_mask on writes.
module mig_app_responder #(
  parameter int unsigned DATA_WIDTH     = 128,
  parameter int unsigned ADDR_WIDTH     = 26,
  parameter int unsigned MEM_DEPTH_LOG2 = 10,
  parameter int unsigned CALIB_CYCLES   = 64,
  parameter int unsigned RD_LATENCY     = 4,
  parameter int unsigned WDF_DEPTH      = 4,
  parameter int unsigned REFRESH_PERIOD = 256,
  parameter int unsigned REFRESH_CYCLES = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [28:0]             app_addr_i,
  input  logic [2:0]              app_cmd_i,
  input  logic                    app_en_i,
  output logic                    app_rdy_o,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data_i,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask_i,
  input  logic                    app_wdf_wren_i,
  input  logic                    app_wdf_end_i,
  output logic                    app_wdf_rdy_o,
  output logic [DATA_WIDTH-1:0]   app_rd_data_o,
  output logic                    app_rd_data_valid_o,
  output logic                    app_rd_data_end_o,
  output logic                    init_calib_complete_o,
  output logic                    app_sr_active_o,
  output logic                    app_ref_ack_o,
  output logic                    app_zq_ack_o,
  output logic                    err_cmd_o
);
  localparam int unsigned NumBytes = DATA_WIDTH / 8;
  localparam int unsigned PtrW     = $clog2(WDF_DEPTH);
  localparam int unsigned MemWords = 1 << MEM_DEPTH_LOG2;
  localparam int unsigned IdxLsb   = 29 - ADDR_WIDTH;

  typedef enum logic [1:0] {StCal, StReady, StRefresh} state_e;

  state_e      state_q;
  logic [31:0] cnt_q;
  logic        calib_done_q;

  logic [DATA_WIDTH-1:0]     mem_q [MemWords];
  logic [DATA_WIDTH-1:0]     fifo_data_q [WDF_DEPTH];
  logic [PtrW:0]             wr_ptr_q, rd_ptr_q;
  logic                      fifo_empty, fifo_full;
  logic                      wcmd_pend_q, wcmd_pend_d;
  logic [MEM_DEPTH_LOG2-1:0] pend_idx_q, pend_idx_d, cmd_idx, wr_idx;
  logic                      cmd_acc, wr_cmd, rd_cmd, bad_cmd, push, beat_avail, commit;
  logic [DATA_WIDTH-1:0]     head_data;
  logic                      err_cmd_q;
  logic [RD_LATENCY-1:0]     rd_vld_q;
  logic [DATA_WIDTH-1:0]     rd_data_q [RD_LATENCY];
  logic                      unused_in;

`ifdef MIG_RESP_MASK_EN
  logic [NumBytes-1:0] fifo_mask_q [WDF_DEPTH];
  logic [NumBytes-1:0] head_mask;
  assign unused_in = ^{app_wdf_end_i, app_addr_i};
`else
  assign unused_in = ^{app_wdf_end_i, app_addr_i, app_wdf_mask_i};
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StCal;
      cnt_q        <= '0;
      calib_done_q <= 1'b0;
    end else begin
      unique case (state_q)
        StCal: begin
          if (cnt_q == CALIB_CYCLES) begin
            state_q      <= StReady;
            cnt_q        <= '0;
            calib_done_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        StReady: begin
          if (REFRESH_PERIOD != 0) begin
            if (cnt_q == REFRESH_PERIOD - 1) begin
              state_q <= StRefresh;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_q + 32'd1;
            end
          end
        end
        StRefresh: begin
          if (cnt_q == REFRESH_CYCLES - 1) begin
            state_q <= StReady;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 32'd1;
          end
        end
        default: state_q <= StCal;
      endcase
    end
  end

  assign cmd_idx    = app_addr_i[IdxLsb +: MEM_DEPTH_LOG2];
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                      (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);

  assign app_rdy_o     = (state_q == StReady) && !wcmd_pend_q;
  assign app_wdf_rdy_o = (state_q != StCal) && !fifo_full;

  assign cmd_acc    = app_en_i && app_rdy_o;
  assign wr_cmd     = cmd_acc && (app_cmd_i == 3'b000);
  assign rd_cmd     = cmd_acc && (app_cmd_i == 3'b001);
  assign bad_cmd    = cmd_acc && (app_cmd_i != 3'b000) && (app_cmd_i != 3'b001);
  assign push       = app_wdf_wren_i && app_wdf_rdy_o;
  assign beat_avail = !fifo_empty || push;
  // An empty FIFO with a same-cycle push bypasses storage; both pointers still advance.
  assign head_data  = fifo_empty ? app_wdf_data_i : fifo_data_q[rd_ptr_q[PtrW-1:0]];
`ifdef MIG_RESP_MASK_EN
  assign head_mask  = fifo_empty ? app_wdf_mask_i : fifo_mask_q[rd_ptr_q[PtrW-1:0]];
`endif

  always_comb begin
    commit      = 1'b0;
    wr_idx      = cmd_idx;
    wcmd_pend_d = wcmd_pend_q;
    pend_idx_d  = pend_idx_q;
    if (wcmd_pend_q) begin
      wr_idx = pend_idx_q;
      if (beat_avail) begin
        commit      = 1'b1;
        wcmd_pend_d = 1'b0;
      end
    end else if (wr_cmd) begin
      if (beat_avail) begin
        commit = 1'b1;
      end else begin
        wcmd_pend_d = 1'b1;
        pend_idx_d  = cmd_idx;
      end
    end
  end

  // Storage arrays carry no reset; RAM contents survive rst_ni.
  always_ff @(posedge clk_i) begin
    if (commit) begin
`ifdef MIG_RESP_MASK_EN
      for (int unsigned b = 0; b < NumBytes; b++) begin
        if (!head_mask[b]) mem_q[wr_idx][8*b +: 8] <= head_data[8*b +: 8];
      end
`else
      mem_q[wr_idx] <= head_data;
`endif
    end
    if (push) begin
      fifo_data_q[wr_ptr_q[PtrW-1:0]] <= app_wdf_data_i;
`ifdef MIG_RESP_MASK_EN
      fifo_mask_q[wr_ptr_q[PtrW-1:0]] <= app_wdf_mask_i;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      wcmd_pend_q <= 1'b0;
      pend_idx_q  <= '0;
      err_cmd_q   <= 1'b0;
    end else begin
      if (push)    wr_ptr_q <= wr_ptr_q + {{PtrW{1'b0}}, 1'b1};
      if (commit)  rd_ptr_q <= rd_ptr_q + {{PtrW{1'b0}}, 1'b1};
      wcmd_pend_q <= wcmd_pend_d;
      pend_idx_q  <= pend_idx_d;
      if (bad_cmd) err_cmd_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) rd_data_q[i] <= '0;
    end else begin
      rd_vld_q[0] <= rd_cmd;
      if (rd_cmd) rd_data_q[0] <= mem_q[cmd_idx];
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        rd_vld_q[i]  <= rd_vld_q[i-1];
        rd_data_q[i] <= rd_data_q[i-1];
      end
    end
  end

  assign app_rd_data_o         = rd_data_q[RD_LATENCY-1];
  assign app_rd_data_valid_o   = rd_vld_q[RD_LATENCY-1];
  assign app_rd_data_end_o     = rd_vld_q[RD_LATENCY-1];
  assign init_calib_complete_o = calib_done_q;
  assign err_cmd_o             = err_cmd_q;
  assign app_sr_active_o       = 1'b0;
  assign app_ref_ack_o         = 1'b0;
  assign app_zq_ack_o          = 1'b0;

endmodule

// File: tb/tb_mig_app_responder.sv
// Bench for mig_app_responder: directed vector table, hand-written corner sequences and
// random traffic, all checked every cycle against a queue-based reference model.
module tb_mig_app_responder;
  localparam int DW    = 128;
  localparam int NB    = DW / 8;
  localparam int CAL   = 64;
  localparam int RL    = 4;
  localparam int WDF   = 4;
  localparam int RP    = 16;
  localparam int RC    = 8;
  localparam int WORDS = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [28:0]   app_addr = '0;
  logic [2:0]    app_cmd = '0;
  logic          app_en = 1'b0;
  logic          app_rdy;
  logic [DW-1:0] app_wdf_data = '0;
  logic [NB-1:0] app_wdf_mask = '0;
  logic          app_wdf_wren = 1'b0;
  logic          app_wdf_end = 1'b0;
  logic          app_wdf_rdy;
  logic [DW-1:0] app_rd_data;
  logic          app_rd_data_valid, app_rd_data_end, init_calib_complete;
  logic          app_sr_active, app_ref_ack, app_zq_ack, err_cmd;

  always #5 clk = ~clk;

  mig_app_responder #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(26), .MEM_DEPTH_LOG2(4), .CALIB_CYCLES(CAL),
    .RD_LATENCY(RL), .WDF_DEPTH(WDF), .REFRESH_PERIOD(RP), .REFRESH_CYCLES(RC)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .app_addr_i(app_addr), .app_cmd_i(app_cmd),
    .app_en_i(app_en), .app_rdy_o(app_rdy), .app_wdf_data_i(app_wdf_data),
    .app_wdf_mask_i(app_wdf_mask), .app_wdf_wren_i(app_wdf_wren), .app_wdf_end_i(app_wdf_end),
    .app_wdf_rdy_o(app_wdf_rdy), .app_rd_data_o(app_rd_data),
    .app_rd_data_valid_o(app_rd_data_valid), .app_rd_data_end_o(app_rd_data_end),
    .init_calib_complete_o(init_calib_complete), .app_sr_active_o(app_sr_active),
    .app_ref_ack_o(app_ref_ack), .app_zq_ack_o(app_zq_ack), .err_cmd_o(err_cmd)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { logic [DW-1:0] data; logic [NB-1:0] mask; } beat_t;
  typedef struct { int due; logic [DW-1:0] data; } rd_t;

  beat_t         m_fifo[$];
  rd_t           m_rdq[$];
  logic [DW-1:0] m_mem [WORDS];
  int            m_edges = 0;
  bit            m_pend = 0;
  int            m_pend_idx = 0;
  bit            m_err = 0;

  task automatic chk(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Timing from the rules: calibrated after CAL+1 edges, then READY RP / REFRESH RC repeating.
  function automatic bit m_calib();
    return m_edges >= CAL + 1;
  endfunction

  function automatic bit m_ready_phase();
    return m_calib() && (((m_edges - (CAL + 1)) % (RP + RC)) < RP);
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_rdq.delete();
    m_edges = 0;
    m_pend  = 0;
    m_err   = 0;
  endtask

  task automatic write_word(int idx, beat_t b);
    for (int i = 0; i < NB; i++) begin
`ifdef MIG_RESP_MASK_EN
      if (b.mask[i]) continue;
`endif
      m_mem[idx][8*i +: 8] = b.data[8*i +: 8];
    end
  endtask

  task automatic check_outputs();
    bit            exp_vld;
    logic [DW-1:0] exp_data;
    exp_vld  = 0;
    exp_data = '0;
    if (m_rdq.size() > 0 && m_rdq[0].due == m_edges) begin
      exp_vld  = 1;
      exp_data = m_rdq[0].data;
      void'(m_rdq.pop_front());
    end
    chk("init_calib_complete", init_calib_complete, m_calib());
    chk("app_rdy", app_rdy, m_ready_phase() && !m_pend);
    chk("app_wdf_rdy", app_wdf_rdy, m_calib() && (m_fifo.size() < WDF));
    chk("app_rd_data_valid", app_rd_data_valid, exp_vld);
    chk("app_rd_data_end", app_rd_data_end, exp_vld);
    if (exp_vld) chk("app_rd_data", app_rd_data, exp_data);
    chk("err_cmd", err_cmd, m_err);
    chk("tied_low", {app_sr_active, app_ref_ack, app_zq_ack}, 3'b000);
  endtask

  task automatic model_edge();
    bit    rdy, wrdy, push, acc;
    int    idx;
    beat_t in_b;
    rd_t   r;
    rdy  = m_ready_phase() && !m_pend;
    wrdy = m_calib() && (m_fifo.size() < WDF);
    push = app_wdf_wren && wrdy;
    acc  = app_en && rdy;
    idx  = int'((app_addr >> 3) % WORDS);
    in_b.data = app_wdf_data;
    in_b.mask = app_wdf_mask;
    if (push) m_fifo.push_back(in_b);
    if (acc && app_cmd == 3'd1) begin
      r.due  = m_edges + RL;
      r.data = m_mem[idx];
      m_rdq.push_back(r);
    end
    if (m_pend) begin
      if (m_fifo.size() > 0) begin
        write_word(m_pend_idx, m_fifo.pop_front());
        m_pend = 0;
      end
    end else if (acc && app_cmd == 3'd0) begin
      if (m_fifo.size() > 0) write_word(idx, m_fifo.pop_front());
      else begin
        m_pend     = 1;
        m_pend_idx = idx;
      end
    end
    if (acc && app_cmd > 3'd1) m_err = 1;
    m_edges++;
  endtask

  task automatic step();
    if (!rst_n) model_reset();
    check_outputs();
    if (rst_n) model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
  endtask

  task automatic wait_rdy_rise();
    int n = 0;
    while (app_rdy && n < 100) begin step(); n++; end
    while (!app_rdy && n < 100) begin step(); n++; end
    chk("wait_rdy_rise_bound", n < 100, 1'b1);
  endtask

  task automatic do_cmd(int word, logic [2:0] cmd);
    int n = 0;
    app_addr = 29'(word * 8);
    app_cmd  = cmd;
    app_en   = 1'b1;
    while (!app_rdy && n < 200) begin step(); n++; end
    step();
    app_en = 1'b0;
    chk("cmd_accept_bound", n < 200, 1'b1);
  endtask

  task automatic do_write(int word, logic [DW-1:0] d, logic [NB-1:0] m);
    int n = 0;
    bit cdone = 0;
    bit ddone = 0;
    app_addr     = 29'(word * 8);
    app_cmd      = 3'd0;
    app_wdf_data = d;
    app_wdf_mask = m;
    while (!(cdone && ddone) && n < 200) begin
      app_en       = !cdone;
      app_wdf_wren = !ddone;
      if (app_en && app_rdy) cdone = 1;
      if (app_wdf_wren && app_wdf_rdy) ddone = 1;
      step();
      n++;
    end
    idle();
    chk("write_handshake_bound", n < 200, 1'b1);
  endtask

  task automatic do_read(int word, output logic [DW-1:0] d);
    int n = 0;
    do_cmd(word, 3'd1);
    while (!app_rd_data_valid && n < 50) begin step(); n++; end
    chk("read_valid_seen", app_rd_data_valid, 1'b1);
    d = app_rd_data;
  endtask

  typedef struct {
    int            word;
    logic [DW-1:0] wdata;
    logic [NB-1:0] mask;
    int            rword;
    logic [DW-1:0] exp;
  } vec_t;

  function automatic vec_t mk(int w, logic [DW-1:0] d, logic [NB-1:0] m, int rw,
                              logic [DW-1:0] e);
    vec_t v;
    v.word = w; v.wdata = d; v.mask = m; v.rword = rw; v.exp = e;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    vec_t          vecs[6];
    logic [DW-1:0] rd;
    logic [DW-1:0] beats[4];
    int            lowcnt;
    int            nstale;
    int            r;

    vecs[0] = mk(3, {16{8'hA5}}, '0, 3, {16{8'hA5}});
    vecs[1] = mk(5, {16{8'hFF}}, '0, 5, {16{8'hFF}});
`ifdef MIG_RESP_MASK_EN
    vecs[2] = mk(5, '0, 16'hFFFE, 5, {{15{8'hFF}}, 8'h00});
`else
    vecs[2] = mk(5, '0, 16'hFFFE, 5, '0);
`endif
    vecs[3] = mk(19, {4{32'hDEADBEEF}}, '0, 3, {4{32'hDEADBEEF}});
    vecs[4] = mk(9, 128'h1234, '0, 9, 128'h1234);
`ifdef MIG_RESP_MASK_EN
    vecs[5] = mk(9, {16{8'h5A}}, 16'h00FF, 9, {{8{8'h5A}}, 64'h1234});
`else
    vecs[5] = mk(9, {16{8'h5A}}, 16'h00FF, 9, {16{8'h5A}});
`endif

    // Reset values and calibration delay.
    #1;
    repeat (3) step();
    rst_n = 1'b1;
    step();
    lowcnt = 0;
    while (!init_calib_complete && lowcnt < 200) begin lowcnt++; step(); end
    chk("calib_low_cycles", lowcnt, 64);
    chk("app_rdy_with_calib", app_rdy, 1'b1);
    chk("err_cmd_after_calib", err_cmd, 1'b0);

    for (int w = 0; w < WORDS; w++) do_write(w, {4{32'h0C0D_E000 + 32'(w)}}, '0);

    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].word, vecs[i].wdata, vecs[i].mask);
      do_read(vecs[i].rword, rd);
      chk($sformatf("vec%0d_readback", i), rd, vecs[i].exp);
    end

    // Write command with data arriving two cycles later.
    wait_rdy_rise();
    app_addr = 29'(7 * 8); app_cmd = 3'd0; app_en = 1'b1; app_wdf_wren = 1'b0;
    step();
    app_en = 1'b0;
    chk("pend_rdy_low", app_rdy, 1'b0);
    step();
    chk("pend_rdy_still_low", app_rdy, 1'b0);
    app_wdf_data = 128'h1234; app_wdf_mask = '0; app_wdf_wren = 1'b1;
    step();
    app_wdf_wren = 1'b0;
    chk("pend_rdy_back", app_rdy, 1'b1);
    do_read(7, rd);
    chk("pend_readback", rd, 128'h1234);

    // Fill the FIFO with no commands, then drain it with four write commands.
    for (int k = 0; k < 4; k++) begin
      beats[k]     = {4{32'hBEEF_0000 + 32'(k)}};
      app_wdf_data = beats[k];
      app_wdf_wren = 1'b1;
      step();
    end
    idle();
    chk("fifo_full_wdf_rdy", app_wdf_rdy, 1'b0);
    for (int k = 0; k < 4; k++) do_cmd(k, 3'd0);
    chk("fifo_drained_wdf_rdy", app_wdf_rdy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      do_read(k, rd);
      chk($sformatf("fifo_beat%0d", k), rd, beats[k]);
    end

    do_cmd(2, 3'd5);
    chk("err_cmd_set", err_cmd, 1'b1);

    // Continuous reads across refresh, then reset with reads in flight.
    wait_rdy_rise();
    lowcnt = 0;
    app_cmd = 3'd1; app_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      app_addr = 29'($urandom);
      if (!app_rdy) lowcnt++;
      step();
    end
    chk("refresh_low_cycles", lowcnt, 16);
    for (int i = 0; i < 5; i++) begin
      app_addr = 29'($urandom);
      step();
    end
    chk("valid_before_reset", app_rd_data_valid, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("valid_drop_on_reset", app_rd_data_valid, 1'b0);
    idle();
    repeat (3) step();
    rst_n = 1'b1;
    nstale = 0;
    for (int i = 0; i < CAL + 30; i++) begin
      if (app_rd_data_valid) nstale++;
      step();
    end
    chk("stale_after_reset", nstale, 0);

    // Random traffic.
    for (int i = 0; i < 2000; i++) begin
      r            = int'($urandom_range(0, 99));
      app_en       = (r < 85);
      app_cmd      = (r < 2) ? 3'($urandom_range(2, 7)) : ((r < 45) ? 3'd0 : 3'd1);
      app_addr     = 29'($urandom);
      app_wdf_wren = 1'($urandom_range(0, 1));
      app_wdf_data = {$urandom, $urandom, $urandom, $urandom};
      app_wdf_mask = 16'($urandom);
      step();
    end
    idle();
    repeat (20) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
